// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive port: FSM states,
// oversampling ratio and the tick divider computation.
package uart_pkg;

   localparam int OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

   // Clocks per oversample tick, truncated; never below 1.
   function automatic int calc_div(input int clk_freq, input int baud);
      int d;
      d = clk_freq / (baud * OVERSAMPLE);
      return (d < 1) ? 1 : d;
   endfunction

endpackage

// File: rtl/uart_rx_port_if.sv
// Processor-facing bundle of the UART receive port: serial line in,
// pop / error-clear strobes in, FIFO head, status and sticky error flags out.
interface uart_rx_port_if;

   logic       rx_232;
   logic       rd_en_pls;
   logic       err_clr;
   logic [7:0] rx_data;
   logic       rx_empty;
   logic       rx_full;
   logic       frame_err;
   logic       overrun_err;
   logic       parity_err;

   modport master (
      output rx_232, rd_en_pls, err_clr,
      input  rx_data, rx_empty, rx_full, frame_err, overrun_err, parity_err
   );

   modport slave (
      input  rx_232, rd_en_pls, err_clr,
      output rx_data, rx_empty, rx_full, frame_err, overrun_err, parity_err
   );

endinterface

// File: rtl/rx_byte_fifo.sv
// First-word-fall-through byte FIFO; a write while full succeeds only when a
// read is accepted in the same cycle. Reads while empty are ignored.
module rx_byte_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             wr_en,
   input  logic             rd_en,
   input  logic [WIDTH-1:0] wr_data,
   output logic [WIDTH-1:0] rd_data,
   output logic             empty,
   output logic             full
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_wr;
   logic             do_rd;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign do_rd   = rd_en && !empty;
   assign do_wr   = wr_en && (!full || do_rd);
   assign rd_data = empty ? '0 : mem[rd_ptr];

   // NOTE: the storage array has no reset; the empty flag masks stale contents.
   always_ff @(posedge clk) begin
      if (do_wr) mem[wr_ptr] <= wr_data;
   end

   // NOTE: sequential state uses <= so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr) wr_ptr <= wr_ptr + AW'(1);
         if (do_rd) rd_ptr <= rd_ptr + AW'(1);
         count <= count + (AW+1)'(do_wr) - (AW+1)'(do_rd);
      end
   end

endmodule

// File: rtl/uart_rx_port.sv
// UART receiver with 16x oversampling, FWFT receive FIFO and sticky errors.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_port
   import uart_pkg::*;
#(
   parameter int CLK_FREQ   = 50000000,
   parameter int BAUD       = 115200,
   parameter int FIFO_DEPTH = 16
) (
   input  logic clk,
   input  logic reset,
   uart_rx_port_if.slave port
);

   localparam int DIV   = calc_div(CLK_FREQ, BAUD);
   localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

   rx_state_t        state;
   logic [1:0]       sync_q;
   logic             rx_s;
   logic             rx_prev;
   logic [DIV_W-1:0] div_cnt;
   logic             tick;
   logic [3:0]       tick_cnt;
   logic [2:0]       bit_cnt;
   logic [7:0]       shift;
   logic             mid_bit;
   logic             par_ok;
   logic             push;
   logic             fifo_full;
   logic             frame_err_q;
   logic             overrun_err_q;

   assign rx_s    = sync_q[1];
   assign tick    = (div_cnt == DIV_W'(DIV - 1));
   assign mid_bit = tick && (tick_cnt == 4'(OVERSAMPLE - 1));
   assign push    = (state == STOP) && mid_bit && rx_s && par_ok;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q  <= 2'b11;
         rx_prev <= 1'b1;
      end else begin
         sync_q  <= {sync_q[0], port.rx_232};
         rx_prev <= rx_s;
      end
   end

   // Divider restarts on the start edge so ticks are phase-aligned to the frame.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                        div_cnt <= '0;
      else if (state == IDLE || tick)   div_cnt <= '0;
      else                              div_cnt <= div_cnt + DIV_W'(1);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= IDLE;
         tick_cnt      <= '0;
         bit_cnt       <= '0;
         shift         <= '0;
         frame_err_q   <= 1'b0;
         overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_ok        <= 1'b1;
         port.parity_err <= 1'b0;
`endif
      end else begin
         // Clear first; a set later in this block wins over a coinciding clear.
         if (port.err_clr) begin
            frame_err_q   <= 1'b0;
            overrun_err_q <= 1'b0;
`ifdef UART_RX_PARITY_EN
            port.parity_err <= 1'b0;
`endif
         end
         if (push && fifo_full && !port.rd_en_pls) overrun_err_q <= 1'b1;

         if (state != IDLE && state != START && tick) tick_cnt <= tick_cnt + 4'd1;

         case (state)
            IDLE: begin
               tick_cnt <= '0;
               bit_cnt  <= '0;
`ifdef UART_RX_PARITY_EN
               par_ok   <= 1'b1;
`endif
               if (rx_prev && !rx_s) state <= START;
            end
            START: begin
               if (tick) begin
                  if (tick_cnt == 4'(OVERSAMPLE / 2 - 1)) begin
                     tick_cnt <= '0;
                     state    <= rx_s ? IDLE : DATA;
                  end else begin
                     tick_cnt <= tick_cnt + 4'd1;
                  end
               end
            end
            DATA: begin
               if (mid_bit) begin
                  shift   <= {rx_s, shift[7:1]};
                  bit_cnt <= bit_cnt + 3'd1;
`ifdef UART_RX_PARITY_EN
                  if (bit_cnt == 3'd7) state <= PARITY;
`else
                  if (bit_cnt == 3'd7) state <= STOP;
`endif
               end
            end
            PARITY: begin
`ifdef UART_RX_PARITY_EN
               if (mid_bit) begin
                  par_ok <= ~^{shift, rx_s};
                  if (^{shift, rx_s}) port.parity_err <= 1'b1;
                  state <= STOP;
               end
`else
               state <= IDLE;
`endif
            end
            STOP: begin
               if (mid_bit) begin
                  if (!rx_s) frame_err_q <= 1'b1;
                  state <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifndef UART_RX_PARITY_EN
   assign par_ok          = 1'b1;
   assign port.parity_err = 1'b0;
`endif

   assign port.frame_err   = frame_err_q;
   assign port.overrun_err = overrun_err_q;
   assign port.rx_full     = fifo_full;

   rx_byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (push),
      .rd_en   (port.rd_en_pls),
      .wr_data (shift),
      .rd_data (port.rx_data),
      .empty   (port.rx_empty),
      .full    (fifo_full)
   );

endmodule

// File: doc/uart_rx_port.md
UART_RX_PORT -- requirements
Module: uart_rx_port

Interface
REQ-001 SHALL have parameter CLK_FREQ, default 50000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, line bit rate.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16, receive FIFO depth; power of two, 4 to 64.
REQ-004 SHALL have port clk, input, 1, single clock for all logic.
REQ-005 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port rx_232, input, 1, asynchronous serial line; idle high.
REQ-007 SHALL have port rd_en_pls, input, 1, one-cycle pop strobe from the processor.
REQ-008 SHALL have port err_clr, input, 1, one-cycle clear of sticky error flags.
REQ-009 SHALL have port rx_data, output, 8, FIFO head byte; valid while rx_empty is 0.
REQ-010 SHALL have ports rx_empty and rx_full, output, 1 each, FIFO status.
REQ-011 SHALL have ports frame_err, overrun_err and parity_err, output, 1 each, sticky error flags.

Function
REQ-012 SHALL pass rx_232 through a 2-flop synchronizer, then generate a 16x oversample tick every DIV = CLK_FREQ/(BAUD*16) clocks, truncated (27 at defaults).
REQ-013 SHALL implement states IDLE, START, DATA, PARITY, STOP, reset to IDLE.
REQ-014 IDLE->START SHALL occur on a synchronized 1->0 transition; a line held low never re-triggers.
REQ-015 START SHALL sample at tick 8; low -> DATA, high -> IDLE (glitch reject, nothing pushed).
REQ-016 DATA SHALL sample 8 bits LSB first, every 16 ticks, at mid-bit.
REQ-017 STOP SHALL sample at mid-bit; 1 -> push byte; 0 -> set frame_err, discard byte; then go to IDLE.
REQ-018 The pushed byte SHALL appear on rx_data, with rx_empty=0, one clk after the stop-bit sample cycle.
REQ-019 FIFO SHALL be first-word-fall-through; rd_en_pls while non-empty SHALL pop, and while empty SHALL be ignored.
REQ-020 Push while full without a same-cycle pop SHALL drop the byte and set overrun_err; push and pop in the same cycle while full SHALL both succeed.
REQ-021 Pointers SHALL wrap modulo FIFO_DEPTH, with a count of log2(FIFO_DEPTH)+1 bits.
REQ-022 err_clr SHALL clear all sticky flags; an error coinciding with err_clr SHALL remain set.

Reset
REQ-023 reset SHALL force state IDLE, empty the FIFO, set rx_data=0x00, rx_empty=1, rx_full=0, all error flags 0, and synchronizer flops to 1.
REQ-024 reset mid-frame SHALL discard the partial byte, with no push after release.

Configuration
REQ-025 With UART_RX_PARITY_EN defined, a PARITY state SHALL follow DATA and check even parity; on mismatch the byte SHALL be discarded and parity_err set.
REQ-026 Without UART_RX_PARITY_EN, DATA SHALL go directly to STOP, and parity_err SHALL be tied to 0.

Structure
REQ-027 Package uart_pkg SHALL hold the rx state enumeration, OVERSAMPLE=16 and the DIV computation function.
REQ-028 The FIFO SHALL be sub-module rx_byte_fifo (write/read strobes, data, empty, full).

Verification
REQ-029 Send 0xA5 at 115200 -> rx_data=0xA5, rx_empty=0, no error flags; one pop -> rx_empty=1.
REQ-030 Hold rx_232 low for 4 ticks then high -> no push, state back to IDLE, rx_empty stays 1.
REQ-031 Send 0x3C with stop bit 0 -> frame_err=1, FIFO empty; err_clr pulse -> frame_err=0.
REQ-032 Send 17 bytes 0x00..0x10 with no pops -> rx_full=1 after 16 bytes, overrun_err=1; pops return 0x00..0x0F in order.
REQ-033 Assert reset during bit 4 of 0x55, release, then send 0x81 -> FIFO holds only 0x81.
REQ-034 With UART_RX_PARITY_EN, send 0x07 with parity bit 0 -> parity_err=1, no push; with parity bit 1 -> 0x07 pushed.
